pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives load/flush of PC, IF/ID,
//  ID/EX, EX/MEM and MEM/WB from I-mem and D-mem wait, load-use hazards and EX-stage redirects.
//  It holds a redirect that arrives while a fetch is outstanding, and keeps stall/flush perf counters.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_ctrl_load_use.sv | 22 ++
 rtl/pipeline_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Stage enables are bundled as {load, flush} pairs.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    ISTALL,
    DSTALL
  } pctrl_state_e;

  typedef struct packed {
    logic load;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STG_RUN  = '{load: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STG_HOLD = '{load: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STG_BUB  = '{load: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard compare between ID/EX load and IF/ID sources.
// x0 never creates a hazard.
module load_use_detect (
  input  logic       id_ex_is_load,
  input  logic [4:0] id_ex_rd,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       if_id_use_rs1,
  input  logic       if_id_use_rs2,
  output logic       lduse
);

  logic hit1;
  logic hit2;

  assign hit1 = if_id_use_rs1 && (if_id_rs1 == id_ex_rd);
  assign hit2 = if_id_use_rs2 && (if_id_rs2 == id_ex_rd);

  assign lduse = id_ex_is_load && (id_ex_rd != 5'd0)
               && (hit1 || hit2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Holds a deferred redirect across fetch waits; keeps perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             id_ex_is_load,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic             br_taken_ex,
  input  logic [31:0]      br_target_ex,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pc_redir_valid,
  output logic [31:0]      pc_redir_target,
  output logic [CNT_W-1:0] cnt_istall,
  output logic [CNT_W-1:0] cnt_dstall,
  output logic [CNT_W-1:0] cnt_lduse,
  output logic [CNT_W-1:0] cnt_flush
);

  pctrl_state_e state_q;
  pctrl_state_e state_n;
  stage_ctrl_t  if_id_c;
  stage_ctrl_t  id_ex_c;
  logic         redir_pend;
  logic         pend_n;
  logic [31:0]  redir_tgt;
  logic [31:0]  tgt_n;
  logic         dstall;
  logic         istall;
  logic         redir;
  logic         lduse;
  logic         lduse_bub;
  logic         pipe_run;

  assign dstall = dmem_req && !dmem_resp;
  assign istall = imem_req && !imem_resp;
  assign redir  = br_taken_ex && !dstall;

  load_use_detect u_lud (
    .id_ex_is_load (id_ex_is_load),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .if_id_use_rs1 (if_id_use_rs1),
    .if_id_use_rs2 (if_id_use_rs2),
    .lduse         (lduse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
    end else begin
      state_q    <= state_n;
      redir_pend <= pend_n;
      redir_tgt  <= tgt_n;
    end
  end

  always_comb begin
    state_n         = dstall ? DSTALL : istall ? ISTALL : RUN;
    load_pc         = 1'b1;
    if_id_c         = STG_RUN;
    id_ex_c         = STG_RUN;
    pipe_run        = 1'b1;
    pc_redir_valid  = 1'b0;
    pc_redir_target = '0;
    pend_n          = redir_pend;
    tgt_n           = redir_tgt;
    lduse_bub       = 1'b0;
    if (rst) begin
      load_pc  = 1'b0;
      if_id_c  = STG_HOLD;
      id_ex_c  = STG_HOLD;
      pipe_run = 1'b0;
      pend_n   = 1'b0;
      tgt_n    = '0;
    end else if (dstall) begin
      load_pc  = 1'b0;
      if_id_c  = STG_HOLD;
      id_ex_c  = STG_HOLD;
      pipe_run = 1'b0;
    end else if (redir) begin
      if_id_c = STG_BUB;
      id_ex_c = STG_BUB;
      pend_n  = istall;
      if (istall) begin
        load_pc = 1'b0;
        tgt_n   = br_target_ex;
      end else begin
        pc_redir_valid  = 1'b1;
        pc_redir_target = br_target_ex;
      end
    end else if (redir_pend) begin
      // fetched word is wrong-path; only ID/EX still sees hazards
      if_id_c   = STG_BUB;
      id_ex_c   = lduse ? STG_BUB : STG_RUN;
      lduse_bub = lduse;
      if (imem_resp) begin
        pc_redir_valid  = 1'b1;
        pc_redir_target = redir_tgt;
        pend_n          = 1'b0;
      end else begin
        load_pc = 1'b0;
      end
    end else if (lduse) begin
      load_pc   = 1'b0;
      if_id_c   = STG_HOLD;
      id_ex_c   = STG_BUB;
      lduse_bub = 1'b1;
    end else if (istall) begin
      load_pc = 1'b0;
      if_id_c = STG_BUB;
    end
  end

  assign load_if_id  = if_id_c.load;
  assign flush_if_id = if_id_c.flush;
  assign load_id_ex  = id_ex_c.load;
  assign flush_id_ex = id_ex_c.flush;
  assign load_ex_mem = pipe_run;
  assign load_mem_wb = pipe_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_istall <= '0;
      cnt_dstall <= '0;
      cnt_lduse  <= '0;
      cnt_flush  <= '0;
    end else begin
      if (state_n == DSTALL) cnt_dstall <= cnt_dstall + CNT_W'(1);
      if (state_n == ISTALL) cnt_istall <= cnt_istall + CNT_W'(1);
      if (lduse_bub)         cnt_lduse  <= cnt_lduse + CNT_W'(1);
      if (redir)             cnt_flush  <= cnt_flush + CNT_W'(1);
    end
  end

  // a pending redirect only ever starts inside a fetch wait
  a_pend_rise : assert property (@(posedge clk) disable iff (rst)
    $rose(redir_pend) |-> state_q == ISTALL);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl against a rule-level model.
// Combinational outputs checked mid-cycle; counters after each edge.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_resp, dmem_req, dmem_resp;
  logic        id_ex_is_load;
  logic [4:0]  id_ex_rd, if_id_rs1, if_id_rs2;
  logic        if_id_use_rs1, if_id_use_rs2;
  logic        br_taken_ex;
  logic [31:0] br_target_ex;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, pc_redir_valid;
  logic [31:0] pc_redir_target;
  logic [31:0] cnt_istall, cnt_dstall, cnt_lduse, cnt_flush;

  int n_chk = 0;
  int n_err = 0;

  logic        m_pend, p_pend;
  logic [31:0] m_tgt, p_tgt;
  logic [31:0] m_ci, m_cd, m_cl, m_cf;
  logic [31:0] p_ci, p_cd, p_cl, p_cf;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_ex_is_load(id_ex_is_load), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .br_taken_ex(br_taken_ex), .br_target_ex(br_target_ex),
    .load_pc(load_pc), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
    .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .pc_redir_valid(pc_redir_valid),
    .pc_redir_target(pc_redir_target),
    .cnt_istall(cnt_istall), .cnt_dstall(cnt_dstall),
    .cnt_lduse(cnt_lduse), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    id_ex_is_load = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    if_id_use_rs1 = 0; if_id_use_rs2 = 0;
    br_taken_ex = 0; br_target_ex = 0;
  endtask

  function automatic logic [7:0] ctl_vec();
    return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
            flush_if_id, flush_id_ex, pc_redir_valid};
  endfunction

  // Expected outputs from the hazard rules; also stages next model state.
  task automatic check_cycle();
    bit ds, is, lu, rd_;
    bit lpc, lif, lex, lpipe, fif, fex, v;
    logic [31:0] t;
    #4;
    ds  = dmem_req && !dmem_resp;
    is  = imem_req && !imem_resp;
    lu  = id_ex_is_load && id_ex_rd != 0 &&
          ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) ||
           (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
    rd_ = br_taken_ex && !ds;
    lpc = 1; lif = 1; lex = 1; lpipe = 1; fif = 0; fex = 0; v = 0; t = 0;
    p_pend = m_pend; p_tgt = m_tgt;
    p_ci = m_ci; p_cd = m_cd; p_cl = m_cl; p_cf = m_cf;
    if (rst) begin
      {lpc, lif, lex, lpipe} = 0;
      p_pend = 0; p_tgt = 0;
      p_ci = 0; p_cd = 0; p_cl = 0; p_cf = 0;
    end else begin
      if (ds) begin
        {lpc, lif, lex, lpipe} = 0;
      end else if (rd_) begin
        fif = 1; fex = 1; p_cf++;
        if (is) begin
          lpc = 0; p_pend = 1; p_tgt = br_target_ex;
        end else begin
          v = 1; t = br_target_ex; p_pend = 0;
        end
      end else if (m_pend) begin
        fif = 1;
        if (lu) begin fex = 1; p_cl++; end
        if (imem_resp) begin v = 1; t = m_tgt; p_pend = 0; end
        else lpc = 0;
      end else if (lu) begin
        lpc = 0; lif = 0; fex = 1; p_cl++;
      end else if (is) begin
        lpc = 0; fif = 1;
      end
      if (ds) p_cd++;
      if (is && !ds) p_ci++;
    end
    chk("ctl", ctl_vec(), {lpc, lif, lex, lpipe, lpipe, fif, fex, v});
    chk("tgt", pc_redir_target, t);
    chk("cnt_i", cnt_istall, m_ci);
    chk("cnt_d", cnt_dstall, m_cd);
    chk("cnt_l", cnt_lduse, m_cl);
    chk("cnt_f", cnt_flush, m_cf);
  endtask

  task automatic tick();
    m_pend = p_pend; m_tgt = p_tgt;
    m_ci = p_ci; m_cd = p_cd; m_cl = p_cl; m_cf = p_cf;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    check_cycle();
    tick();
  endtask

  initial begin
    idle();
    rst = 1;
    m_pend = 0; m_tgt = 0;
    m_ci = 0; m_cd = 0; m_cl = 0; m_cf = 0;
    @(posedge clk); #1;
    check_cycle();
    chk("rst_ctl", {24'd0, ctl_vec()}, 0);
    tick();
    step();

    // straight-line flow
    idle();
    for (int i = 0; i < 20; i++) step();
    chk("t1_ctl", {24'd0, ctl_vec()}, 32'hF8);
    chk("t1_cnt", {cnt_istall, cnt_flush}, 0);

    // lw x5 ; add x6,x5,x1
    id_ex_is_load = 1; id_ex_rd = 5;
    if_id_rs1 = 5; if_id_rs2 = 1; if_id_use_rs1 = 1; if_id_use_rs2 = 1;
    check_cycle();
    chk("t2_ctl", {24'd0, ctl_vec()}, 8'b00111010);
    tick();
    idle();
    chk("t2_cnt", cnt_lduse, 1);

    // immediate redirect
    br_taken_ex = 1; br_target_ex = 32'h100;
    check_cycle();
    chk("t3_ctl", {24'd0, ctl_vec()}, 8'b11111111);
    chk("t3_tgt", pc_redir_target, 32'h100);
    tick();
    idle();
    chk("t3_cnt", cnt_flush, 1);

    // redirect during 3-cycle fetch wait
    imem_req = 1; br_taken_ex = 1; br_target_ex = 32'h200;
    step();
    br_taken_ex = 0; br_target_ex = 0;
    for (int i = 0; i < 2; i++) begin
      check_cycle();
      chk("t4_hold", load_pc, 0);
      tick();
    end
    imem_resp = 1;
    check_cycle();
    chk("t4_ctl", {24'd0, ctl_vec()}, 8'b11111101);
    chk("t4_tgt", pc_redir_target, 32'h200);
    tick();
    check_cycle();
    chk("t4_clr", pc_redir_valid, 0);
    tick();
    idle();

    // 4-cycle dmem wait with a branch pending in EX
    dmem_req = 1; br_taken_ex = 1; br_target_ex = 32'h300;
    for (int i = 0; i < 4; i++) begin
      check_cycle();
      chk("t5_frz", {24'd0, ctl_vec()}, 0);
      tick();
    end
    chk("t5_cnt", cnt_dstall, 4);
    dmem_resp = 1;
    check_cycle();
    chk("t5_tgt", {pc_redir_valid, pc_redir_target}, {1'b1, 32'h300});
    tick();
    idle();

    // reset with a redirect pending
    imem_req = 1; br_taken_ex = 1; br_target_ex = 32'h400;
    step();
    idle();
    rst = 1; imem_req = 1;
    step();
    rst = 0; imem_req = 0; imem_resp = 0;
    check_cycle();
    chk("t6_cnt", cnt_flush, 0);
    tick();
    imem_req = 1; imem_resp = 1;
    check_cycle();
    chk("t6_nored", pc_redir_valid, 0);
    tick();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      imem_req      = ($urandom_range(0, 9) < 7);
      imem_resp     = $urandom_range(0, 1) == 1;
      dmem_req      = ($urandom_range(0, 4) == 0);
      dmem_resp     = $urandom_range(0, 1) == 1;
      id_ex_is_load = $urandom_range(0, 1) == 1;
      id_ex_rd      = 5'($urandom_range(0, 3));
      if_id_rs1     = 5'($urandom_range(0, 3));
      if_id_rs2     = 5'($urandom_range(0, 3));
      if_id_use_rs1 = $urandom_range(0, 1) == 1;
      if_id_use_rs2 = $urandom_range(0, 1) == 1;
      br_taken_ex   = ($urandom_range(0, 4) == 0);
      br_target_ex  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
